dac_sigma_delta: RTL and testbench



---
 rtl/dac_sigma_delta.sv | 66 ++++++
 tb/tb_dac_sigma_delta.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/dac_sigma_delta.sv
// dac_sigma_delta: first-order sigma-delta DAC fed from a small sample FIFO, one sample per OSR clocks.
module dac_sigma_delta #(
  parameter int W     = 16,
  parameter int OSR   = 256,
  parameter int DEPTH = 4
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_lock,
  input  logic [W-1:0] i_sample,
  input  logic         i_valid,
  output logic         o_ready,
  output logic         o_dac_out,
  output logic         o_tick,
  output logic         o_underrun
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(OSR);
  localparam logic [CW-1:0] LAST = CW'(OSR - 1);
  localparam logic [W-1:0] MID = {1'b1, {(W-1){1'b0}}};
  logic [W-1:0] r_fifo [DEPTH];
  logic [AW-1:0] r_wp, r_rp;
  logic [AW:0] r_cnt;
  logic [CW-1:0] r_phase;
  logic [W-1:0] r_acc, r_cur;
  logic r_dac;
  logic w_empty, w_full, w_push, w_pop;
  logic [W:0] w_sum;
  assign w_empty    = r_cnt == '0;
  assign w_full     = r_cnt == (AW+1)'(DEPTH);
  assign o_ready    = i_lock & ~i_rst & ~w_full;
  assign o_tick     = i_lock & ~i_rst & (r_phase == LAST);
  assign o_underrun = o_tick & w_empty;
  assign w_push     = i_valid & o_ready;
  assign w_pop      = o_tick & ~w_empty;
  assign w_sum      = {1'b0, r_acc} + {1'b0, r_cur};
  assign o_dac_out  = r_dac;
  always_ff @(posedge i_clk)
    if (w_push) r_fifo[r_wp] <= i_sample;
  // Losing lock is a synchronous return to the reset state, queued samples included.
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) begin
      r_wp <= '0;
      r_rp <= '0;
      r_cnt <= '0;
      r_phase <= '0;
      r_acc <= '0;
      r_cur <= MID;
      r_dac <= 1'b0;
    end else if (!i_lock) begin
      r_wp <= '0;
      r_rp <= '0;
      r_cnt <= '0;
      r_phase <= '0;
      r_acc <= '0;
      r_cur <= MID;
      r_dac <= 1'b0;
    end else begin
      r_wp <= r_wp + AW'(w_push);
      r_rp <= r_rp + AW'(w_pop);
      r_cnt <= r_cnt + (AW+1)'(w_push) - (AW+1)'(w_pop);
      r_phase <= o_tick ? '0 : r_phase + CW'(1);
      r_cur <= w_pop ? r_fifo[r_rp] : r_cur;
      {r_dac, r_acc} <= w_sum;
    end
endmodule

// File: tb/tb_dac_sigma_delta.sv
// tb_dac_sigma_delta: randomized and directed checks of dac_sigma_delta against a queue-based model.
module tb_dac_sigma_delta;
  localparam int W = 16, OSR = 4, DEPTH = 4;
  logic clk = 0, rst = 1, lock = 0, valid = 0;
  logic [W-1:0] sample = '0;
  logic ready, dac, tick, und;
  int checks = 0, errors = 0;
  int m_q[$];
  int m_phase = 0, m_cur = 1 << (W - 1), m_acc = 0, m_s = 0;
  bit m_dac = 0, m_push = 0, m_tk = 0;
  always #5 clk = ~clk;
  dac_sigma_delta #(.W(W), .OSR(OSR), .DEPTH(DEPTH)) dut (
    .i_clk(clk), .i_rst(rst), .i_lock(lock), .i_sample(sample), .i_valid(valid),
    .o_ready(ready), .o_dac_out(dac), .o_tick(tick), .o_underrun(und)
  );
  function automatic bit e_ready();
    return lock && !rst && (m_q.size() < DEPTH);
  endfunction
  function automatic bit e_tick();
    return lock && !rst && (m_phase == OSR - 1);
  endfunction
  function automatic bit e_und();
    return e_tick() && (m_q.size() == 0);
  endfunction
  always @(posedge clk or posedge rst)
    if (rst || !lock) begin
      m_q.delete();
      m_phase = 0;
      m_cur = 1 << (W - 1);
      m_acc = 0;
      m_dac = 0;
    end else begin
      m_push = valid && e_ready();
      m_tk = e_tick();
      m_s = m_acc + m_cur;
      m_dac = m_s >= (1 << W);
      m_acc = m_s % (1 << W);
      if (m_tk && m_q.size() > 0) m_cur = m_q.pop_front();
      if (m_push) m_q.push_back(int'(sample));
      m_phase = (m_phase + 1) % OSR;
    end
  task automatic chk(input string n, input logic a, input logic e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got %b expected %b at %0t", n, a, e, $time);
    end
  endtask
  task automatic chk_int(input string n, input int a, input int e);
    checks++;
    if (a != e) begin
      errors++;
      $display("FAIL %s got %0d expected %0d at %0t", n, a, e, $time);
    end
  endtask
  always @(negedge clk) begin
    chk("ready", ready, e_ready());
    chk("tick", tick, e_tick());
    chk("underrun", und, e_und());
    chk("dac_out", dac, m_dac);
  end
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic wait_tick(output bit u, output int n);
    n = 0;
    u = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!tick && n < 3 * OSR);
    if (!tick) chk_int("tick_timeout", n, -1);
    else u = und;
  endtask
  task automatic relock();
    lock = 0;
    valid = 0;
    step();
    lock = 1;
  endtask
  task automatic density(input logic [W-1:0] v, input int exp);
    int ones;
    relock();
    valid = 1;
    sample = v;
    repeat (4 * OSR + 8) step();
    ones = 0;
    repeat (1000) begin
      @(negedge clk);
      ones += int'(dac);
    end
    chk_int($sformatf("density_%h", v), ones, exp);
    valid = 0;
    step();
  endtask
  initial begin
    bit u;
    int n, ones;
    logic [9:0] pat;
    repeat (2) step();
    rst = 0;
    lock = 1;
    valid = 1;
    sample = 16'h1234;
    step();
    step();
    valid = 0;
    #2 rst = 1;
    #1;
    chk("rst_ready", ready, 1'b0);
    chk("rst_dac", dac, 1'b0);
    chk("rst_tick", tick, 1'b0);
    chk("rst_und", und, 1'b0);
    step();
    rst = 0;
    @(negedge clk);
    chk("post_rst_ready", ready, 1'b1);
    wait_tick(u, n);
    chk_int("post_rst_tick_cycle", n, OSR - 1);
    chk("post_rst_empty", u, 1'b1);
    density(16'h8000, 500);
    density(16'h4000, 250);
    density(16'h0000, 0);
    relock();
    valid = 1;
    sample = $urandom;
    pat = 10'b0100011111;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk($sformatf("bp_ready_%0d", i), ready, pat[i]);
    end
    valid = 0;
    step();
    relock();
    valid = 1;
    sample = 16'hC000;
    step();
    valid = 0;
    wait_tick(u, n);
    chk("first_tick_loads", u, 1'b0);
    for (int i = 0; i < 5; i++) begin
      wait_tick(u, n);
      chk($sformatf("underrun_%0d", i), u, 1'b1);
    end
    ones = 0;
    repeat (1000) begin
      @(negedge clk);
      ones += int'(dac);
    end
    chk_int("density_hold_c000", ones, 750);
    relock();
    valid = 1;
    sample = 16'h5555;
    repeat (3) step();
    valid = 0;
    lock = 0;
    step();
    @(negedge clk);
    chk("lockloss_ready", ready, 1'b0);
    chk("lockloss_dac", dac, 1'b0);
    step();
    lock = 1;
    wait_tick(u, n);
    chk_int("relock_tick_cycle", n, OSR);
    chk("relock_underrun", u, 1'b1);
    step();
    for (int i = 0; i < 4000; i++) begin
      valid = (i < 2000) ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 7) == 0);
      sample = $urandom;
      lock = ($urandom_range(0, 199) != 0);
      rst = ($urandom_range(0, 499) == 0);
      step();
    end
    rst = 0;
    step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
